conv1d_out_packer: RTL and testbench

Downstream stage of the conv1d CFU. It accepts one quantized int32 result per output channel from the accumulator/quant path and saturates it to int8. Four consecutive results are packed little-endian into a 32-bit word, and packed words are buffered in a small FIFO. The CPU drains the FIFO one word per read, so results can be written back with 4-byte stores without stalling the MAC engine.

---
 rtl/conv1d_pkg.sv | 10 +
 rtl/conv1d_sync_fifo.sv | 60 ++++++
 rtl/conv1d_out_packer.sv | 100 ++++++++++
 tb/tb_conv1d_out_packer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/conv1d_pkg.sv
// conv1d_pkg: shared conv1d widths, the int32->int8 clip and the packer state encoding.
package conv1d_pkg;
  localparam int BYTE_SIZE     = 8;
  localparam int INT32_SIZE    = 32;
  localparam int KERNEL_LENGTH = 8;
  typedef enum logic {PACK, FLUSH_PEND} packer_state_t;
  function automatic logic [7:0] sat8(input logic [31:0] v);
    return ($signed(v) > 32'sd127) ? 8'h7f : ($signed(v) < -32'sd128) ? 8'h80 : v[7:0];
  endfunction
endpackage

// File: rtl/conv1d_sync_fifo.sv
// conv1d_sync_fifo: DEPTH x WIDTH synchronous FIFO with a registered read port.
//   clk, rst_n           clock, async active-low reset
//   i_clear              sync clear of pointers/count (wins over push/pop)
//   i_push, i_push_data  write one word (ignored when full)
//   i_pop                read one word (ignored when empty)
//   o_rd_data/o_rd_valid popped word, valid for one cycle after the pop
//   o_count/o_full/o_empty occupancy
module conv1d_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_rd_valid,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign o_count = r_count;
  assign o_full  = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign w_push  = i_push && !o_full && !i_clear;
  assign w_pop   = i_pop && !o_empty && !i_clear;
  // Storage has no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_push_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
    end else if (i_clear) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr    <= r_rptr + 1'b1;
        o_rd_data <= r_mem[r_rptr];
      end
      o_rd_valid <= w_pop;
      r_count    <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/conv1d_out_packer.sv
// conv1d_out_packer: saturates int32 results to int8, packs 4 per little-endian word, buffers words for CPU reads.
//   clk, rst_n              clock, async active-low reset
//   i_clear                 sync clear of lanes, FIFO and flags (highest priority)
//   i_in_valid/i_in_data    one signed result per cycle; o_in_ready accepts it
//   i_flush                 pulse: emit the partial word zero-padded
//   i_rd_en                 pop one word -> o_rd_data/o_rd_valid next cycle
//   o_count, o_lane         FIFO occupancy, next byte lane
//   o_sat_flag/o_ovf_flag/o_udf_flag  sticky clip / double-flush / empty-read flags
module conv1d_out_packer #(
  parameter int BYTE_SIZE  = 8,
  parameter int INT32_SIZE = 32,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clear,
  input  logic                    i_in_valid,
  input  logic [INT32_SIZE-1:0]   i_in_data,
  output logic                    o_in_ready,
  input  logic                    i_flush,
  input  logic                    i_rd_en,
  output logic [INT32_SIZE-1:0]   o_rd_data,
  output logic                    o_rd_valid,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic [1:0]              o_lane,
  output logic                    o_sat_flag,
  output logic                    o_ovf_flag,
  output logic                    o_udf_flag
);
  import conv1d_pkg::*;
  packer_state_t r_state, w_state_nxt;
  logic [1:0] r_lane;
  logic [INT32_SIZE-1:0] r_hold, w_push_data;
  logic [BYTE_SIZE-1:0] w_byte;
  logic w_full, w_empty, w_pend, w_accept, w_clip, w_word_push, w_flush_push, w_push;
  logic r_sat, r_ovf, r_udf;
  assign w_pend      = r_state == FLUSH_PEND;
  assign o_in_ready  = !w_pend && (r_lane != 2'd3 || !w_full);
  assign w_accept    = i_in_valid && o_in_ready && !i_clear;
  assign w_byte      = sat8(i_in_data);
  assign w_clip      = $signed(i_in_data) > 32'sd127 || $signed(i_in_data) < -32'sd128;
  assign w_word_push = w_accept && r_lane == 2'd3;
  // Partial word leaves either on an immediate flush with room, or when a pending flush finds room.
  assign w_flush_push = !i_clear && r_lane != 2'd0 && !w_full && (w_pend || (i_flush && !w_accept));
  assign w_push      = w_word_push || w_flush_push;
  // Unused lanes of hold are always zero, so a partial word needs no masking.
  assign w_push_data = w_word_push ? {w_byte, r_hold[INT32_SIZE-BYTE_SIZE-1:0]} : r_hold;
  assign o_lane      = r_lane;
  assign o_sat_flag  = r_sat;
  assign o_ovf_flag  = r_ovf;
  assign o_udf_flag  = r_udf;
  // A flush that coincides with an accept is deferred; an emptied lane set just returns to PACK.
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = w_pend ? ((r_lane == 2'd0 || !w_full) ? PACK : FLUSH_PEND) :
                  (i_flush && (w_accept || (r_lane != 2'd0 && w_full))) ? FLUSH_PEND : PACK;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PACK;
      r_lane  <= 2'd0;
      r_hold  <= '0;
      r_sat   <= 1'b0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else if (i_clear) begin
      r_state <= PACK;
      r_lane  <= 2'd0;
      r_hold  <= '0;
      r_sat   <= 1'b0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) begin
        r_lane <= 2'd0;
        r_hold <= '0;
      end else if (w_accept) begin
        r_hold[r_lane*BYTE_SIZE +: BYTE_SIZE] <= w_byte;
        r_lane <= r_lane + 2'd1;
      end
      r_sat <= r_sat | (w_accept & w_clip);
      r_ovf <= r_ovf | (w_pend & i_flush);
      r_udf <= r_udf | (i_rd_en & w_empty);
    end
  end
  conv1d_sync_fifo #(.WIDTH(INT32_SIZE), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (i_clear),
    .i_push     (w_push),
    .i_push_data(w_push_data),
    .i_pop      (i_rd_en),
    .o_rd_data  (o_rd_data),
    .o_rd_valid (o_rd_valid),
    .o_count    (o_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );
endmodule

// File: tb/tb_conv1d_out_packer.sv
// tb_conv1d_out_packer: directed vector table plus hand sequences for stall, pending flush, drain, clear and async reset.
module tb_conv1d_out_packer;
  logic clk = 0, rst_n = 0, clear = 0, in_valid = 0, flush = 0, rd_en = 0;
  logic [31:0] in_data = 0;
  logic in_ready, rd_valid, sat_flag, ovf_flag, udf_flag;
  logic [31:0] rd_data;
  logic [4:0] count;
  logic [1:0] lane;
  int n_vec = 0, n_miss = 0;
  always #5 clk = ~clk;
  conv1d_out_packer dut (
    .clk(clk), .rst_n(rst_n), .i_clear(clear), .i_in_valid(in_valid), .i_in_data(in_data),
    .o_in_ready(in_ready), .i_flush(flush), .i_rd_en(rd_en), .o_rd_data(rd_data),
    .o_rd_valid(rd_valid), .o_count(count), .o_lane(lane), .o_sat_flag(sat_flag),
    .o_ovf_flag(ovf_flag), .o_udf_flag(udf_flag)
  );
  typedef struct {
    logic v; logic [31:0] d; logic fl; logic rd;
    logic [4:0] cnt; logic [1:0] ln; logic rdy; logic rv; logic [31:0] rdat; logic sat; logic udf;
  } vec_t;
  vec_t tbl[17];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic cyc(input logic v, input logic [31:0] d, input logic fl, input logic rd, input logic cl);
    in_valid = v; in_data = d; flush = fl; rd_en = rd; clear = cl;
    @(posedge clk); #1;
    in_valid = 0; flush = 0; rd_en = 0; clear = 0;
  endtask
  function automatic logic [31:0] word(input int j);
    return {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
  endfunction
  initial begin
    //         v  d            fl rd  cnt ln rdy rv rdat          sat udf
    tbl[0]  = '{1, 32'd1,        0, 0, 0, 1, 1, 0, 32'h0,         0, 0};
    tbl[1]  = '{1, 32'd2,        0, 0, 0, 2, 1, 0, 32'h0,         0, 0};
    tbl[2]  = '{1, 32'd3,        0, 0, 0, 3, 1, 0, 32'h0,         0, 0};
    tbl[3]  = '{1, 32'd4,        0, 0, 1, 0, 1, 0, 32'h0,         0, 0};
    tbl[4]  = '{0, 32'd0,        0, 1, 0, 0, 1, 1, 32'h04030201,  0, 0};
    tbl[5]  = '{1, 32'd300,      0, 0, 0, 1, 1, 0, 32'h0,         1, 0};
    tbl[6]  = '{1, -32'sd500,    0, 0, 0, 2, 1, 0, 32'h0,         1, 0};
    tbl[7]  = '{1, 32'd5,        0, 0, 0, 3, 1, 0, 32'h0,         1, 0};
    tbl[8]  = '{0, 32'd0,        1, 0, 1, 0, 1, 0, 32'h0,         1, 0};
    tbl[9]  = '{0, 32'd0,        0, 1, 0, 0, 1, 1, 32'h0005807F,  1, 0};
    tbl[10] = '{0, 32'd0,        0, 1, 0, 0, 1, 0, 32'h0,         1, 1};
    tbl[11] = '{0, 32'd0,        1, 0, 0, 0, 1, 0, 32'h0,         1, 1};
    tbl[12] = '{1, 32'hFFFFFFFF, 0, 0, 0, 1, 1, 0, 32'h0,         1, 1};
    tbl[13] = '{1, -32'sd128,    0, 0, 0, 2, 1, 0, 32'h0,         1, 1};
    tbl[14] = '{1, 32'd127,      0, 0, 0, 3, 1, 0, 32'h0,         1, 1};
    tbl[15] = '{1, 32'd128,      0, 0, 1, 0, 1, 0, 32'h0,         1, 1};
    tbl[16] = '{0, 32'd0,        0, 1, 0, 0, 1, 1, 32'h7F7F80FF,  1, 1};
    #12;
    chk("reset in_ready", 32'(in_ready), 1);
    chk("reset rd_valid", 32'(rd_valid), 0);
    chk("reset rd_data", rd_data, 0);
    chk("reset count", 32'(count), 0);
    chk("reset lane", 32'(lane), 0);
    chk("reset flags", {29'd0, sat_flag, ovf_flag, udf_flag}, 0);
    @(posedge clk); #1; rst_n = 1;
    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].fl, tbl[i].rd, 0);
      chk($sformatf("vec%0d count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d lane", i), 32'(lane), 32'(tbl[i].ln));
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(tbl[i].rv));
      if (tbl[i].rv) chk($sformatf("vec%0d rd_data", i), rd_data, tbl[i].rdat);
      chk($sformatf("vec%0d sat_flag", i), 32'(sat_flag), 32'(tbl[i].sat));
      chk($sformatf("vec%0d udf_flag", i), 32'(udf_flag), 32'(tbl[i].udf));
    end
    // Fill to full, stall on lane 3, pop to unblock.
    cyc(0, 0, 0, 0, 1);
    chk("clear flags", {29'd0, sat_flag, ovf_flag, udf_flag}, 0);
    for (int k = 0; k < 64; k++) cyc(1, 32'(k), 0, 0, 0);
    chk("full count", 32'(count), 16);
    chk("full ready lane0", 32'(in_ready), 1);
    for (int k = 64; k < 67; k++) cyc(1, 32'(k), 0, 0, 0);
    chk("full lane3", 32'(lane), 3);
    chk("full stall ready", 32'(in_ready), 0);
    cyc(1, 32'd67, 0, 0, 0);
    chk("stalled lane", 32'(lane), 3);
    chk("stalled count", 32'(count), 16);
    cyc(1, 32'd67, 0, 1, 0);
    chk("unstall count", 32'(count), 15);
    chk("unstall rd_valid", 32'(rd_valid), 1);
    chk("unstall rd_data", rd_data, word(0));
    chk("unstall ready", 32'(in_ready), 1);
    cyc(1, 32'd67, 0, 0, 0);
    chk("word17 count", 32'(count), 16);
    chk("word17 lane", 32'(lane), 0);
    // Pending flush with a full FIFO, then double flush.
    cyc(1, 32'd100, 0, 0, 0);
    cyc(1, 32'd101, 0, 0, 0);
    chk("pre-flush lane", 32'(lane), 2);
    cyc(0, 0, 1, 0, 0);
    chk("pend ready", 32'(in_ready), 0);
    chk("pend lane", 32'(lane), 2);
    chk("pend ovf", 32'(ovf_flag), 0);
    cyc(0, 0, 1, 0, 0);
    chk("double flush ovf", 32'(ovf_flag), 1);
    cyc(0, 0, 0, 1, 0);
    chk("pend pop count", 32'(count), 15);
    chk("pend pop data", rd_data, word(1));
    chk("pend still waiting", 32'(in_ready), 0);
    cyc(0, 0, 0, 0, 0);
    chk("pend pushed count", 32'(count), 16);
    chk("pend pushed lane", 32'(lane), 0);
    chk("back to PACK", 32'(in_ready), 1);
    for (int j = 2; j <= 16; j++) begin
      cyc(0, 0, 0, 1, 0);
      chk($sformatf("drain word%0d", j), rd_data, word(j));
    end
    cyc(0, 0, 0, 1, 0);
    chk("drain partial", rd_data, 32'h00006564);
    chk("drain valid", 32'(rd_valid), 1);
    chk("drain empty", 32'(count), 0);
    cyc(0, 0, 0, 1, 0);
    chk("empty read valid", 32'(rd_valid), 0);
    chk("empty read udf", 32'(udf_flag), 1);
    // Final-lane accept together with a pop at count 5.
    cyc(0, 0, 0, 0, 1);
    for (int k = 0; k < 23; k++) cyc(1, 32'(k), 0, 0, 0);
    chk("c5 count", 32'(count), 5);
    chk("c5 lane", 32'(lane), 3);
    cyc(1, 32'd23, 0, 1, 0);
    chk("push+pop count", 32'(count), 5);
    chk("push+pop lane", 32'(lane), 0);
    chk("push+pop data", rd_data, word(0));
    // Clear with in_valid high drops the input.
    cyc(1, 32'd9, 0, 0, 0);
    cyc(1, 32'd9, 0, 0, 1);
    chk("clear lane", 32'(lane), 0);
    chk("clear count", 32'(count), 0);
    chk("clear rd_valid", 32'(rd_valid), 0);
    // Async reset mid-word.
    for (int k = 0; k < 16; k++) cyc(1, 32'(k), 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 32'd1000, 0, 0, 0);
    cyc(1, 32'd7, 0, 0, 0);
    chk("pre-reset lane", 32'(lane), 2);
    chk("pre-reset count", 32'(count), 3);
    chk("pre-reset sat", 32'(sat_flag), 1);
    #2 rst_n = 0;
    #1;
    chk("async count", 32'(count), 0);
    chk("async lane", 32'(lane), 0);
    chk("async rd_data", rd_data, 0);
    chk("async flags", {29'd0, sat_flag, ovf_flag, udf_flag}, 0);
    chk("async ready", 32'(in_ready), 1);
    @(posedge clk); #1; rst_n = 1;
    cyc(0, 0, 0, 1, 0);
    chk("post-reset empty read", 32'(rd_valid), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
